// File: rtl/l2_cache_pkg.sv
// Shared constants and types for the 8-way L2 cache model: geometry,
// miss/fill FSM encoding and the lowest-invalid-way helper.
package l2_cache_pkg;

  localparam int WAYS        = 8;
  localparam int TAG_WIDTH   = 12;
  localparam int INDEX_WIDTH = 14;
  localparam int LINE_WIDTH  = 512;
  localparam int SETS        = 2 ** INDEX_WIDTH;
  localparam int WAY_WIDTH   = 3;
  localparam int PLRU_WIDTH  = WAYS - 1;
  localparam int ADDR_WIDTH  = TAG_WIDTH + INDEX_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_FETCH     = 3'd3,
    ST_WAIT_RESP = 3'd4,
    ST_FILL      = 3'd5
  } state_t;

  // Lowest-numbered way whose valid bit is clear (0 when all are valid).
  function automatic logic [WAY_WIDTH-1:0] first_invalid(input logic [WAYS-1:0] valid);
    logic [WAY_WIDTH-1:0] way;
    way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) way = w[WAY_WIDTH-1:0];
    end
    return way;
  endfunction

endpackage

// File: rtl/miss_fill_controller_if.sv
// Miss request, set lookup, hit notification, memory and fill signals of the
// miss/fill controller; master is the controller side, slave the cache/memory side.
interface miss_fill_controller_if;
  import l2_cache_pkg::*;

  logic                      missValid;
  logic                      missReady;
  logic [TAG_WIDTH-1:0]      missTag;
  logic [INDEX_WIDTH-1:0]    missIndex;
  logic                      missWrite;
  logic [WAYS-1:0]           setValid;
  logic [WAYS-1:0]           setDirty;
  logic [WAYS*TAG_WIDTH-1:0] setTags;
  logic [LINE_WIDTH-1:0]     victimData;
  logic [INDEX_WIDTH-1:0]    lookupIndex;
  logic [WAY_WIDTH-1:0]      victimWay;
  logic                      hitValid;
  logic [INDEX_WIDTH-1:0]    hitIndex;
  logic [WAY_WIDTH-1:0]      hitWay;
  logic                      memReqValid;
  logic                      memReqReady;
  logic                      memReqWrite;
  logic [ADDR_WIDTH-1:0]     memReqAddr;
  logic [LINE_WIDTH-1:0]     memWriteData;
  logic                      memRespValid;
  logic [LINE_WIDTH-1:0]     memRespData;
  logic                      fillWrite;
  logic [WAY_WIDTH-1:0]      fillWay;
  logic [INDEX_WIDTH-1:0]    fillIndex;
  logic [TAG_WIDTH-1:0]      fillTag;
  logic                      fillDirty;
  logic [LINE_WIDTH-1:0]     fillData;
  logic                      missDone;

  modport master (
    input  missValid, missTag, missIndex, missWrite, setValid, setDirty, setTags,
           victimData, hitValid, hitIndex, hitWay, memReqReady, memRespValid, memRespData,
    output missReady, lookupIndex, victimWay, memReqValid, memReqWrite, memReqAddr,
           memWriteData, fillWrite, fillWay, fillIndex, fillTag, fillDirty, fillData, missDone
  );

  modport slave (
    output missValid, missTag, missIndex, missWrite, setValid, setDirty, setTags,
           victimData, hitValid, hitIndex, hitWay, memReqReady, memRespValid, memRespData,
    input  missReady, lookupIndex, victimWay, memReqValid, memReqWrite, memReqAddr,
           memWriteData, fillWrite, fillWay, fillIndex, fillTag, fillDirty, fillData, missDone
  );

endinterface

// File: rtl/plru_tree.sv
// 7-bit tree pseudo-LRU for one 8-way set: victim lookup and access update.
// Node n has children 2n+1 / 2n+2; a 0 bit points at the lower half.
module plru_tree
  import l2_cache_pkg::*;
(
  input  logic [PLRU_WIDTH-1:0] bits,
  input  logic [WAY_WIDTH-1:0]  way,
  output logic [WAY_WIDTH-1:0]  victim,
  output logic [PLRU_WIDTH-1:0] updated
);

  logic v2_s;
  logic v1_s;

  // Follow the node bits from the root down to a leaf.
  always_comb begin
    v2_s = bits[0];
    if (v2_s) v1_s = bits[2];
    else      v1_s = bits[1];
    victim = {v2_s, v1_s, bits[3'd3 + {1'b0, v2_s, v1_s}]};
  end

  // Point every node on the accessed way's path away from it.
  always_comb begin
    updated = bits;
    updated[0] = ~way[2];
    updated[3'd1 + {2'b00, way[2]}] = ~way[1];
    updated[3'd3 + {1'b0, way[2:1]}] = ~way[0];
  end

endmodule

// File: rtl/miss_fill_controller.sv
// Miss handling for the 8-way L2 model: victim selection, dirty writeback,
// line fetch and fill, plus the per-set PLRU state shared with hit updates.
module miss_fill_controller
  import l2_cache_pkg::*;
(
  input logic                    clock,
  input logic                    reset,
  miss_fill_controller_if.master bus
);

  state_t                 state_r;
  state_t                 state_next_s;
  logic [TAG_WIDTH-1:0]   tag_r;
  logic [INDEX_WIDTH-1:0] index_r;
  logic                   write_r;
  logic [WAY_WIDTH-1:0]   victim_way_r;
  logic [TAG_WIDTH-1:0]   victim_tag_r;
  logic [LINE_WIDTH-1:0]  line_r;
  logic [PLRU_WIDTH-1:0]  plru_r [SETS];

  logic [WAY_WIDTH-1:0]   plru_victim_s;
  logic [PLRU_WIDTH-1:0]  fill_plru_s;
  logic [PLRU_WIDTH-1:0]  hit_plru_s;
  logic [WAY_WIDTH-1:0]   hit_victim_unused_s;
  logic [WAY_WIDTH-1:0]   sel_way_s;
  logic                   sel_dirty_s;
  logic [TAG_WIDTH-1:0]   sel_tag_s;

  plru_tree u_fill_plru (
    .bits    (plru_r[index_r]),
    .way     (victim_way_r),
    .victim  (plru_victim_s),
    .updated (fill_plru_s)
  );

  plru_tree u_hit_plru (
    .bits    (plru_r[bus.hitIndex]),
    .way     (bus.hitWay),
    .victim  (hit_victim_unused_s),
    .updated (hit_plru_s)
  );

  assign bus.lookupIndex = index_r;
  assign bus.victimWay   = victim_way_r;

  // Victim choice: an invalid way is always preferred over evicting a live line.
  always_comb begin
    if (&bus.setValid) sel_way_s = plru_victim_s;
    else               sel_way_s = first_invalid(bus.setValid);
    sel_dirty_s = bus.setValid[sel_way_s] & bus.setDirty[sel_way_s];
    sel_tag_s   = bus.setTags[sel_way_s*TAG_WIDTH +: TAG_WIDTH];
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Next state and outputs decoded from the current state.
  always_comb begin
    state_next_s     = state_r;
    bus.missReady    = 1'b0;
    bus.memReqValid  = 1'b0;
    bus.memReqWrite  = 1'b0;
    bus.memReqAddr   = '0;
    bus.memWriteData = '0;
    bus.fillWrite    = 1'b0;
    bus.fillWay      = '0;
    bus.fillIndex    = '0;
    bus.fillTag      = '0;
    bus.fillDirty    = 1'b0;
    bus.fillData     = '0;
    bus.missDone     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        bus.missReady = 1'b1;
        if (bus.missValid) state_next_s = ST_SELECT;
        else               state_next_s = ST_IDLE;
      end
      ST_SELECT: begin
        if (sel_dirty_s) state_next_s = ST_WRITEBACK;
        else             state_next_s = ST_FETCH;
      end
      ST_WRITEBACK: begin
        bus.memReqValid  = 1'b1;
        bus.memReqWrite  = 1'b1;
        bus.memReqAddr   = {victim_tag_r, index_r};
        bus.memWriteData = bus.victimData;
        if (bus.memReqReady) state_next_s = ST_FETCH;
        else                 state_next_s = ST_WRITEBACK;
      end
      ST_FETCH: begin
        bus.memReqValid = 1'b1;
        bus.memReqAddr  = {tag_r, index_r};
        if (bus.memReqReady) state_next_s = ST_WAIT_RESP;
        else                 state_next_s = ST_FETCH;
      end
      ST_WAIT_RESP: begin
        if (bus.memRespValid) state_next_s = ST_FILL;
        else                  state_next_s = ST_WAIT_RESP;
      end
      ST_FILL: begin
        bus.fillWrite = 1'b1;
        bus.fillWay   = victim_way_r;
        bus.fillIndex = index_r;
        bus.fillTag   = tag_r;
        bus.fillDirty = write_r;
        bus.fillData  = line_r;
        bus.missDone  = 1'b1;
        state_next_s  = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Miss context, chosen victim and returned line.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_r        <= '0;
      index_r      <= '0;
      write_r      <= 1'b0;
      victim_way_r <= '0;
      victim_tag_r <= '0;
      line_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.missValid) begin
            tag_r   <= bus.missTag;
            index_r <= bus.missIndex;
            write_r <= bus.missWrite;
          end
        end
        ST_SELECT: begin
          victim_way_r <= sel_way_s;
          victim_tag_r <= sel_tag_s;
        end
        ST_WAIT_RESP: begin
          if (bus.memRespValid) line_r <= bus.memRespData;
        end
        default: begin
        end
      endcase
    end
  end

  // Per-set PLRU; the fill write comes last so it wins over a same-set hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) plru_r[s] <= '0;
    end else begin
      if (bus.hitValid)       plru_r[bus.hitIndex] <= hit_plru_s;
      if (state_r == ST_FILL) plru_r[index_r]      <= fill_plru_s;
    end
  end

endmodule

// File: tb/tb_miss_fill_controller.sv
// Directed bench for miss_fill_controller: a table of miss vectors plus
// hand-written hit/fill interaction, request stall and reset sequences.
module tb_miss_fill_controller;
  import l2_cache_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  miss_fill_controller_if bus ();

  miss_fill_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [LINE_WIDTH-1:0] line_of(input logic [2:0] way, input logic [13:0] idx);
    return {32{4'hD, 1'b0, way, idx[7:0]}};
  endfunction

  function automatic logic [TAG_WIDTH-1:0] tag_of(input logic [2:0] way);
    return 12'h100 + {9'd0, way};
  endfunction

  // Data array model: the line stored at (lookupIndex, victimWay).
  assign bus.victimData = line_of(bus.victimWay, bus.lookupIndex);

  task automatic check(input string name, input logic [LINE_WIDTH-1:0] act,
                       input logic [LINE_WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_miss(input logic [13:0] idx, input logic [11:0] tag, input logic wr,
                          input logic [7:0] valid, input logic [7:0] dirty,
                          input logic [2:0] exp_way, input logic exp_wb, input int stall,
                          input logic hit_en, input logic [13:0] hit_idx,
                          input logic [2:0] hit_way);
    logic [LINE_WIDTH-1:0] resp;
    resp = {16{tag, idx, 6'h2A}};
    @(negedge clock);
    check("idle_ready", bus.missReady, 1'b1);
    bus.missValid = 1'b1;
    bus.missTag   = tag;
    bus.missIndex = idx;
    bus.missWrite = wr;
    bus.setValid  = valid;
    bus.setDirty  = dirty;
    @(negedge clock);
    bus.missValid = 1'b0;
    check("select_ready", bus.missReady, 1'b0);
    check("lookup_index", bus.lookupIndex, idx);
    check("select_no_req", bus.memReqValid, 1'b0);
    @(negedge clock);
    check("victim_way", bus.victimWay, exp_way);
    if (exp_wb) begin
      check("wb_valid", bus.memReqValid, 1'b1);
      check("wb_write", bus.memReqWrite, 1'b1);
      check("wb_addr", bus.memReqAddr, {tag_of(exp_way), idx});
      check("wb_data", bus.memWriteData, line_of(exp_way, idx));
      @(negedge clock);
    end
    check("fetch_valid", bus.memReqValid, 1'b1);
    check("fetch_write", bus.memReqWrite, 1'b0);
    check("fetch_addr", bus.memReqAddr, {tag, idx});
    if (stall > 0) begin
      bus.memReqReady = 1'b0;
      bus.missValid   = 1'b1;
      bus.missIndex   = idx ^ 14'h3FFF;
      for (int i = 0; i < stall; i++) begin
        @(negedge clock);
        check("stall_valid", bus.memReqValid, 1'b1);
        check("stall_addr", bus.memReqAddr, {tag, idx});
        check("stall_ready", bus.missReady, 1'b0);
        check("stall_lookup", bus.lookupIndex, idx);
      end
      bus.missValid   = 1'b0;
      bus.missIndex   = idx;
      bus.memReqReady = 1'b1;
    end
    @(negedge clock);
    check("wait_no_req", bus.memReqValid, 1'b0);
    check("wait_no_fill", bus.fillWrite, 1'b0);
    bus.memRespValid = 1'b1;
    bus.memRespData  = resp;
    @(negedge clock);
    bus.memRespValid = 1'b0;
    bus.memRespData  = '0;
    check("fill_write", bus.fillWrite, 1'b1);
    check("fill_done", bus.missDone, 1'b1);
    check("fill_way", bus.fillWay, exp_way);
    check("fill_index", bus.fillIndex, idx);
    check("fill_tag", bus.fillTag, tag);
    check("fill_dirty", bus.fillDirty, wr);
    check("fill_data", bus.fillData, resp);
    if (hit_en) begin
      bus.hitValid = 1'b1;
      bus.hitIndex = hit_idx;
      bus.hitWay   = hit_way;
    end
    @(negedge clock);
    bus.hitValid = 1'b0;
    check("done_pulse", bus.missDone, 1'b0);
    check("back_idle", bus.missReady, 1'b1);
  endtask

  typedef struct {
    logic [13:0] idx;
    logic [11:0] tag;
    logic        wr;
    logic [7:0]  valid;
    logic [7:0]  dirty;
    logic [2:0]  exp_way;
    logic        exp_wb;
    int          stall;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    // Set 9 evolves across vectors 1..3 through the PLRU fills.
    vecs[0] = '{14'd5, 12'h0AB, 1'b0, 8'h0F, 8'h00, 3'd4, 1'b0, 0};
    vecs[1] = '{14'd9, 12'h123, 1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 0};
    vecs[2] = '{14'd9, 12'h124, 1'b0, 8'hFF, 8'h00, 3'd4, 1'b0, 5};
    vecs[3] = '{14'd9, 12'h125, 1'b1, 8'hFF, 8'h04, 3'd2, 1'b1, 0};
    vecs[4] = '{14'd3, 12'h0F0, 1'b0, 8'hF7, 8'hFF, 3'd3, 1'b0, 0};
    vecs[5] = '{14'd3, 12'h0F1, 1'b1, 8'hFE, 8'h00, 3'd0, 1'b0, 0};

    reset            = 1'b1;
    bus.missValid    = 1'b0;
    bus.missTag      = '0;
    bus.missIndex    = '0;
    bus.missWrite    = 1'b0;
    bus.setValid     = '0;
    bus.setDirty     = '0;
    bus.hitValid     = 1'b0;
    bus.hitIndex     = '0;
    bus.hitWay       = '0;
    bus.memReqReady  = 1'b1;
    bus.memRespValid = 1'b0;
    bus.memRespData  = '0;
    for (int w = 0; w < WAYS; w++) bus.setTags[w*TAG_WIDTH +: TAG_WIDTH] = tag_of(w[2:0]);

    repeat (2) @(negedge clock);
    check("rst_ready", bus.missReady, 1'b1);
    check("rst_req_valid", bus.memReqValid, 1'b0);
    check("rst_req_addr", bus.memReqAddr, '0);
    check("rst_fill", bus.fillWrite, 1'b0);
    check("rst_done", bus.missDone, 1'b0);
    check("rst_victim", bus.victimWay, 3'd0);
    check("rst_lookup", bus.lookupIndex, 14'd0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_miss(vecs[v].idx, vecs[v].tag, vecs[v].wr, vecs[v].valid, vecs[v].dirty,
               vecs[v].exp_way, vecs[v].exp_wb, vecs[v].stall, 1'b0, 14'd0, 3'd0);
    end

    // Hits to ways 0..7 leave set 20 pointing at way 0, then at way 4 after filling it.
    for (int w = 0; w < WAYS; w++) begin
      @(negedge clock);
      bus.hitValid = 1'b1;
      bus.hitIndex = 14'd20;
      bus.hitWay   = w[2:0];
    end
    @(negedge clock);
    bus.hitValid = 1'b0;
    run_miss(14'd20, 12'h0C1, 1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 0, 1'b0, 14'd0, 3'd0);
    run_miss(14'd20, 12'h0C2, 1'b0, 8'hFF, 8'h00, 3'd4, 1'b0, 0, 1'b0, 14'd0, 3'd0);

    // Same-set hit during FILL: the fill update must win.
    run_miss(14'd30, 12'h0D1, 1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 0, 1'b1, 14'd30, 3'd4);
    run_miss(14'd30, 12'h0D2, 1'b0, 8'hFF, 8'h00, 3'd4, 1'b0, 0, 1'b0, 14'd0, 3'd0);

    // Different-set hit during FILL: both sets update.
    run_miss(14'd40, 12'h0E1, 1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 0, 1'b1, 14'd41, 3'd0);
    run_miss(14'd40, 12'h0E2, 1'b0, 8'hFF, 8'h00, 3'd4, 1'b0, 0, 1'b0, 14'd0, 3'd0);
    run_miss(14'd41, 12'h0E3, 1'b0, 8'hFF, 8'h00, 3'd4, 1'b0, 0, 1'b0, 14'd0, 3'd0);

    // Reset while waiting for the response; the late response is ignored.
    @(negedge clock);
    bus.missValid = 1'b1;
    bus.missTag   = 12'h055;
    bus.missIndex = 14'd50;
    bus.missWrite = 1'b0;
    bus.setValid  = 8'h00;
    bus.setDirty  = 8'h00;
    @(negedge clock);
    bus.missValid = 1'b0;
    @(negedge clock);
    check("rst_seq_fetch", bus.memReqValid, 1'b1);
    @(negedge clock);
    check("rst_seq_wait", bus.memReqValid, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.memRespValid = 1'b1;
    bus.memRespData  = {16{32'hDEADBEEF}};
    check("rst_seq_ready", bus.missReady, 1'b1);
    @(negedge clock);
    bus.memRespValid = 1'b0;
    check("rst_seq_no_fill", bus.fillWrite, 1'b0);
    check("rst_seq_no_done", bus.missDone, 1'b0);
    check("rst_seq_idle", bus.missReady, 1'b1);
    check("rst_seq_no_req", bus.memReqValid, 1'b0);
    @(negedge clock);
    check("rst_seq_still_idle", bus.fillWrite, 1'b0);
    // Reset also cleared set 9's PLRU history.
    run_miss(14'd9, 12'h126, 1'b0, 8'hFF, 8'h00, 3'd0, 1'b0, 0, 1'b0, 14'd0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miss_fill_controller.md
Name: miss_fill_controller

Overview:
- Miss-side counterpart to the per-set hit detector for the 8-way L2 model.
- Accepts a miss for (tag, index) and picks a victim way: first invalid way, else tree pseudo-LRU.
- Writes back a dirty victim, fetches the line from memory and writes it into the cache arrays.
- Owns the per-set PLRU state, which is also updated by hit notifications.

Parameters:
- WAYS, 8, associativity; fixed at 8 (7-bit PLRU tree)
- TAG_WIDTH, 12, tag bits
- INDEX_WIDTH, 14, set-index bits; SETS = 2**INDEX_WIDTH
- LINE_WIDTH, 512, data bits per line

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- missValid  in  1  miss request valid
- missReady  out  1  controller can accept a miss
- missTag  in  TAG_WIDTH  tag of missing line
- missIndex  in  INDEX_WIDTH  set of missing line
- missWrite  in  1  miss caused by a write; filled line is marked dirty
- setValid  in  WAYS  valid bits of the set at lookupIndex
- setDirty  in  WAYS  dirty bits of the set at lookupIndex
- setTags  in  WAYS*TAG_WIDTH  tags of the set; way w is in bits [w*TAG_WIDTH +: TAG_WIDTH]
- victimData  in  LINE_WIDTH  data array output for (lookupIndex, victimWay)
- lookupIndex  out  INDEX_WIDTH  set being read, equal to the latched missIndex
- victimWay  out  3  selected victim way
- hitValid  in  1  hit occurred this cycle
- hitIndex  in  INDEX_WIDTH  set of the hit
- hitWay  in  3  way that hit
- memReqValid  out  1  memory request valid
- memReqReady  in  1  memory accepts request
- memReqWrite  out  1  1 = writeback, 0 = line read
- memReqAddr  out  TAG_WIDTH+INDEX_WIDTH  line address {tag, index}
- memWriteData  out  LINE_WIDTH  writeback data
- memRespValid  in  1  read data valid, single cycle
- memRespData  in  LINE_WIDTH  read data
- fillWrite  out  1  write the cache arrays this cycle
- fillWay  out  3  way to write
- fillIndex  out  INDEX_WIDTH  set to write
- fillTag  out  TAG_WIDTH  new tag; valid is set to 1
- fillDirty  out  1  new dirty bit, equal to latched missWrite
- fillData  out  LINE_WIDTH  new line data
- missDone  out  1  one-cycle pulse when the fill completes

Behaviour:
- Reset:
  - Synchronous, active-high; state goes to IDLE.
  - All outputs 0 except missReady = 1.
  - All PLRU bits cleared to 0.
  - Any outstanding request is abandoned. A memRespValid arriving after reset is ignored.
- States: IDLE, SELECT, WRITEBACK, FETCH, WAIT_RESP, FILL.
- IDLE:
  - missReady = 1.
  - On missValid, latch tag, index and write, then go to SELECT.
- SELECT (one cycle):
  - victimWay = lowest-numbered way with setValid = 0.
  - If all ways are valid, victimWay = PLRU victim of the set.
  - victimWay is registered and held until IDLE.
  - Next state is WRITEBACK if the victim is valid and dirty, else FETCH.
- PLRU tree:
  - Node 0 is the root; node n has children 2n+1 and 2n+2.
  - A node bit of 0 points to the lower half, 1 to the upper half.
  - The victim path follows the bits from the root.
  - Access update sets every node on the accessed way's path to point away from it.
  - With all bits 0, the victim is way 0.
- WRITEBACK:
  - memReqValid = 1, memReqWrite = 1.
  - memReqAddr = {victim tag, index}, memWriteData = victimData.
  - All request fields hold stable until memReqReady. On handshake, go to FETCH.
- FETCH:
  - memReqValid = 1, memReqWrite = 0, memReqAddr = {missTag, index}.
  - On handshake, go to WAIT_RESP.
- WAIT_RESP:
  - On memRespValid, capture memRespData and go to FILL.
- FILL (one cycle):
  - fillWrite = 1 and missDone = 1.
  - fillWay, fillIndex, fillTag, fillDirty and fillData are driven from the latched values.
  - PLRU of the set is updated for fillWay. Next state is IDLE.
- Hit updates:
  - Applied in every state in the cycle hitValid is asserted.
  - If a hit and a fill target the same index in the same cycle, the fill update wins.
  - Different indices are both applied.
- memReqValid deasserts the cycle after its handshake.
- missValid is ignored whenever missReady = 0.
- Minimum latency with a clean victim, memReqReady = 1 and the response one cycle after the request:
  - accept at t0, SELECT at t1, request at t2, response at t3, fillWrite/missDone at t4.
- A dirty victim adds at least one cycle for the writeback handshake.

Decomposition:
- Package l2_cache_pkg:
  - WAYS, TAG_WIDTH, INDEX_WIDTH, LINE_WIDTH
  - way index width (3)
  - state encoding constants
- Sub-module plru_tree, combinational:
  - computes the victim from 7 bits
  - computes the updated 7 bits from (bits, way)
  - instantiated once for the victim/fill path and once for the hit path.

Test Plan:
- Reset, then a miss on index 5, tag 0x0AB, with setValid = 0x0F: victimWay = 4, no writeback, memReqAddr = {0x0AB, 5}, fillWay = 4, missDone at t4 when memReqReady = 1.
- All ways valid, set freshly reset, way 0 dirty: victim 0, WRITEBACK carries way 0's tag and victimData, then FETCH, then FILL with fillDirty = missWrite.
- Hits to ways 0..7 in order on one index, then a full-set miss: victim = way 0. A second miss after filling way 0: victim = way 4.
- memReqReady held low for 5 cycles in FETCH: memReqValid and memReqAddr stay stable and no new miss is accepted (missReady = 0).
- hitValid with the same index and cycle as FILL: the resulting PLRU equals the fill-only update. With a different index, both sets update.
- Reset asserted in WAIT_RESP and memRespValid pulsed next cycle: returns to IDLE, no fillWrite, missReady = 1.
